// File: rtl/fpga_ccff_loader.sv
// fpga_ccff_loader: Wishbone slave that serialises 32-bit bitstream words onto
// the fabric configuration chain and captures the chain tail for readback.
module fpga_ccff_loader #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        prog_clk_o,
  output logic        prog_reset_o,
  output logic        ccff_head_o,
  input  logic        ccff_tail_i,
  output logic        irq_o
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_LOW = 2'd1, S_HIGH = 2'd2} state_t;
  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  state_t      r_state, w_state_nx;
  logic [2:0]  r_ctrl;
  logic        r_buf_full, r_done, r_ack, r_pclk, r_head, r_prst, r_irq;
  logic [31:0] r_buf, r_tx, r_rx, r_rxdata, r_count, r_dat;
  logic [4:0]  r_bit_cnt;
  logic [7:0]  r_div;

  logic [2:0]  w_adr;
  logic        w_acc_new, w_wr, w_abort, w_tx_wr, w_w1c, w_stall, w_msb;
  logic        w_div_last, w_bit_end, w_sample, w_word_end, w_load;
  logic [31:0] w_tx_nx, w_rd_val;
  logic        w_unused;

  assign w_unused   = ^{wbs_sel_i, wbs_adr_i[31:5], wbs_adr_i[1:0]};
  assign w_adr      = wbs_adr_i[4:2];
  // An access already acked this cycle is the tail of the same transfer.
  assign w_acc_new  = wbs_stb_i & wbs_cyc_i & ~r_ack;
  assign w_wr       = w_acc_new & wbs_we_i;
  assign w_abort    = w_wr & (w_adr == 3'd0) & wbs_dat_i[0];
  assign w_tx_wr    = w_wr & (w_adr == 3'd2);
  assign w_w1c      = w_wr & (w_adr == 3'd1) & wbs_dat_i[2];
  assign w_msb      = r_ctrl[1];
  assign w_div_last = (r_div == DIV_LAST);
  assign w_bit_end  = (r_state == S_HIGH) & w_div_last;
  assign w_sample   = (r_state == S_LOW) & w_div_last;
  assign w_word_end = w_bit_end & (r_bit_cnt == 5'd31);
  // A full buffer only accepts a new word in the cycle the shifter drains it.
  assign w_stall    = w_tx_wr & r_buf_full & ~w_load;

  always_comb begin
    w_state_nx = r_state;
    w_load     = 1'b0;
    case (r_state)
      S_IDLE: if (r_buf_full && !r_ctrl[0]) begin
        w_load     = 1'b1;
        w_state_nx = S_LOW;
      end
      S_LOW:  if (w_div_last) w_state_nx = S_HIGH;
      S_HIGH: if (w_div_last) begin
        if (r_bit_cnt != 5'd31) begin
          w_state_nx = S_LOW;
        end else if (r_buf_full) begin
          w_load     = 1'b1;
          w_state_nx = S_LOW;
        end else begin
          w_state_nx = S_IDLE;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
    if (w_abort) begin
      w_state_nx = S_IDLE;
      w_load     = 1'b0;
    end
  end

  always_comb begin
    w_tx_nx = r_tx;
    if (w_load)         w_tx_nx = r_buf;
    else if (w_bit_end) w_tx_nx = w_msb ? {r_tx[30:0], 1'b0} : {1'b0, r_tx[31:1]};
  end

  always_comb begin
    w_rd_val = '0;
    case (w_adr)
      3'd0:    w_rd_val = {29'd0, r_ctrl};
      3'd1:    w_rd_val = {29'd0, r_done, r_buf_full, (r_state != S_IDLE)};
      3'd3:    w_rd_val = r_rxdata;
      3'd4:    w_rd_val = r_count;
      default: w_rd_val = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) r_state <= S_IDLE;
    else            r_state <= w_state_nx;
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_ctrl <= 3'b001;  r_buf_full <= 1'b0; r_done <= 1'b0; r_ack <= 1'b0;
      r_pclk <= 1'b0;    r_head <= 1'b0;     r_prst <= 1'b1; r_irq <= 1'b0;
      r_buf <= '0; r_tx <= '0; r_rx <= '0; r_rxdata <= '0; r_count <= '0;
      r_dat <= '0; r_bit_cnt <= '0; r_div <= '0;
    end else begin
      r_ack <= w_acc_new & ~w_stall;
      r_dat <= (w_acc_new & ~w_stall & ~wbs_we_i) ? w_rd_val : 32'd0;
      if (w_wr && (w_adr == 3'd0)) r_ctrl <= wbs_dat_i[2:0];

      if (w_abort) begin
        r_buf_full <= 1'b0;
      end else if (w_tx_wr && !w_stall) begin
        r_buf      <= wbs_dat_i;
        r_buf_full <= 1'b1;
      end else if (w_load) begin
        r_buf_full <= 1'b0;
      end

      r_div <= ((w_state_nx != r_state) || (r_state == S_IDLE)) ? 8'd0 : r_div + 8'd1;
      if (w_load)         r_bit_cnt <= 5'd0;
      else if (w_bit_end) r_bit_cnt <= r_bit_cnt + 5'd1;
      r_tx <= w_tx_nx;
      if (w_sample) r_rx <= w_msb ? {r_rx[30:0], ccff_tail_i} : {ccff_tail_i, r_rx[31:1]};
      if (w_word_end) r_rxdata <= r_rx;

      if (w_abort)        r_count <= '0;
      else if (w_bit_end) r_count <= r_count + 32'd1;
      if (w_word_end)     r_done <= 1'b1;
      else if (w_w1c)     r_done <= 1'b0;

      r_irq  <= r_done & r_ctrl[2];
      r_prst <= r_ctrl[0];
      r_pclk <= (w_state_nx == S_HIGH);
      // Head only moves when the tx register shifts, i.e. at prog_clk fall.
      r_head <= (w_state_nx != S_IDLE) & (w_msb ? w_tx_nx[31] : w_tx_nx[0]);
    end
  end

  assign wbs_ack_o    = r_ack;
  assign wbs_dat_o    = r_dat;
  assign prog_clk_o   = r_pclk;
  assign prog_reset_o = r_prst;
  assign ccff_head_o  = r_head;
  assign irq_o        = r_irq;

endmodule

// File: tb/tb_fpga_ccff_loader.sv
// Testbench for fpga_ccff_loader: Wishbone-driven scenarios with a 32-deep
// configuration chain model on prog_clk and a bit-history reference model.
module tb_fpga_ccff_loader;
  localparam int CLK_DIV = 2;
  localparam logic [2:0] A_CTRL = 3'd0, A_STATUS = 3'd1, A_TX = 3'd2, A_RX = 3'd3, A_CNT = 3'd4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        stb = 1'b0, cyc_s = 1'b0, we = 1'b0;
  logic [3:0]  sel = 4'hF;
  logic [31:0] adr = '0, wdat = '0;
  logic        ack, pclk, preset, head, irq;
  logic [31:0] rdat;
  logic        tail = 1'b0;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [31:0] chain = '0;
  bit          hist[$];
  bit          head_q[$];
  int          edge_q[$];
  logic [31:0] exp_words[$];
  bit          exp_msb = 1'b0;
  logic [31:0] exp_count = '0;
  logic [31:0] exp_rx = '0;

  fpga_ccff_loader #(.CLK_DIV(CLK_DIV)) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n), .wbs_stb_i(stb), .wbs_cyc_i(cyc_s),
    .wbs_we_i(we), .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(wdat),
    .wbs_ack_o(ack), .wbs_dat_o(rdat), .prog_clk_o(pclk), .prog_reset_o(preset),
    .ccff_head_o(head), .ccff_tail_i(tail), .irq_o(irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Fabric chain: shifts head in on every prog_clk rise, tail is the 32nd stage.
  always @(posedge pclk) begin
    chain <= {chain[30:0], head};
    tail  <= chain[30];
    hist.push_back(head);
    head_q.push_back(head);
    edge_q.push_back(cyc);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required completion earlier", $time);
    $fatal(1, "watchdog");
  end

  function automatic bit word_bit(input logic [31:0] w, input bit msb, input int i);
    return msb ? w[31-i] : w[i];
  endfunction

  // The tail bits seen during the last word are the head bits sent 32 shifts earlier.
  function automatic logic [31:0] model_rx(input bit msb);
    logic [31:0] r;
    int n, idx;
    bit b;
    r = '0;
    n = hist.size();
    for (int i = 0; i < 32; i++) begin
      idx = n - 64 + i;
      b = (idx >= 0) ? hist[idx] : 1'b0;
      if (msb) r[31-i] = b;
      else     r[i] = b;
    end
    return r;
  endfunction

  function automatic int seq_errs();
    int e;
    e = 0;
    if (head_q.size() != exp_words.size() * 32) return 9999;
    for (int w = 0; w < exp_words.size(); w++)
      for (int i = 0; i < 32; i++)
        if (head_q[w*32+i] != word_bit(exp_words[w], exp_msb, i)) e++;
    return e;
  endfunction

  function automatic int gap_errs();
    int e;
    e = 0;
    for (int i = 1; i < edge_q.size(); i++)
      if (edge_q[i] - edge_q[i-1] != 2 * CLK_DIV) e++;
    return e;
  endfunction

  task automatic clear_mon();
    head_q.delete();
    edge_q.delete();
    exp_words.delete();
  endtask

  task automatic bus(input logic w, input logic [2:0] a, input logic [31:0] d,
                     output logic [31:0] q, output int waited);
    bit got;
    got = 1'b0;
    waited = 0;
    q = '0;
    @(negedge clk);
    stb = 1'b1; cyc_s = 1'b1; we = w; adr = {27'd0, a, 2'b00}; wdat = d;
    while (!got && waited < 1000) begin
      @(posedge clk);
      #1;
      waited++;
      if (ack) begin
        got = 1'b1;
        q = rdat;
      end
    end
    stb = 1'b0; cyc_s = 1'b0; we = 1'b0;
    if (!got) begin
      checks++; failures++;
      $display("FAIL bus_ack_timeout: reg %0d got no ack, required ack within 1000 cycles", a);
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    logic [31:0] q;
    int n;
    bus(1'b1, a, d, q, n);
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] q);
    int n;
    bus(1'b0, a, 32'd0, q, n);
  endtask

  task automatic wait_idle();
    logic [31:0] s;
    int tries;
    s = 32'h3;
    tries = 0;
    while (s[1:0] != 2'b00 && tries < 2000) begin
      rd(A_STATUS, s);
      tries++;
    end
    if (s[1:0] != 2'b00) begin
      checks++; failures++;
      $display("FAIL idle_timeout: STATUS=%h, required busy=0 buf_full=0", s);
    end
  endtask

  task automatic wait_edges(input int n);
    int t;
    t = 0;
    while (edge_q.size() < n && t < 5000) begin
      @(posedge clk);
      t++;
    end
    #1;
    if (edge_q.size() < n) begin
      checks++; failures++;
      $display("FAIL edge_timeout: %0d prog_clk edges, required %0d", edge_q.size(), n);
    end
  endtask

  task automatic test_reset();
    bit ack_seen;
    logic [31:0] q;
    ack_seen = 1'b0;
    #2 rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (ack) ack_seen = 1'b1;
    end
    checks++; if (preset !== 1'b1) begin failures++; $display("FAIL rst_prog_reset: got %b required 1", preset); end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (ack) ack_seen = 1'b1;
    end
    checks++; if (ack_seen !== 1'b0) begin failures++; $display("FAIL rst_ack: got ack=1 required 0"); end
    checks++; if (pclk !== 1'b0) begin failures++; $display("FAIL rst_prog_clk: got %b required 0", pclk); end
    checks++; if (head !== 1'b0) begin failures++; $display("FAIL rst_head: got %b required 0", head); end
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL rst_irq: got %b required 0", irq); end
    checks++; if (rdat !== 32'd0) begin failures++; $display("FAIL rst_dat: got %h required 0", rdat); end
    rd(A_CTRL, q);
    checks++; if (q !== 32'h1) begin failures++; $display("FAIL rst_ctrl: got %h required 00000001", q); end
    rd(A_STATUS, q);
    checks++; if (q !== 32'h0) begin failures++; $display("FAIL rst_status: got %h required 0", q); end
    rd(A_CNT, q);
    checks++; if (q !== 32'h0) begin failures++; $display("FAIL rst_count: got %h required 0", q); end
    rd(A_RX, q);
    checks++; if (q !== 32'h0) begin failures++; $display("FAIL rst_rxdata: got %h required 0", q); end
    rd(A_TX, q);
    checks++; if (q !== 32'h0) begin failures++; $display("FAIL txdata_read: got %h required 0", q); end
  endtask

  task automatic test_single_word();
    logic [31:0] q;
    wr(A_CTRL, 32'h0);
    clear_mon();
    exp_msb = 1'b0;
    exp_words.push_back(32'h5);
    wr(A_TX, 32'h5);
    wait_idle();
    exp_count += 32;
    checks++; if (seq_errs() != 0) begin failures++; $display("FAIL single_seq: %0d bad head bits, required 0", seq_errs()); end
    checks++; if (edge_q.size() != 32) begin failures++; $display("FAIL single_edges: got %0d required 32", edge_q.size()); end
    checks++; if (gap_errs() != 0) begin failures++; $display("FAIL single_period: %0d bad gaps, required 0", gap_errs()); end
    rd(A_CNT, q);
    checks++; if (q !== exp_count) begin failures++; $display("FAIL single_count: got %h required %h", q, exp_count); end
    rd(A_STATUS, q);
    checks++; if (q !== 32'h4) begin failures++; $display("FAIL single_status: got %h required 00000004", q); end
    rd(A_RX, q);
    checks++; if (q !== model_rx(1'b0)) begin failures++; $display("FAIL single_rx: got %h required %h", q, model_rx(1'b0)); end
    checks++; if (preset !== 1'b0) begin failures++; $display("FAIL single_prog_reset: got %b required 0", preset); end
  endtask

  task automatic test_random_words();
    logic [31:0] q, w;
    bit msb;
    for (int r = 0; r < 2; r++) begin
      msb = 1'($urandom_range(0, 1));
      wr(A_CTRL, {30'd0, msb, 1'b0});
      clear_mon();
      exp_msb = msb;
      for (int k = 0; k < 2; k++) begin
        w = $urandom;
        exp_words.push_back(w);
        wr(A_TX, w);
      end
      wait_idle();
      exp_count += 64;
      checks++; if (seq_errs() != 0) begin failures++; $display("FAIL rand_seq msb=%0d: %0d bad bits, required 0", msb, seq_errs()); end
      checks++; if (gap_errs() != 0) begin failures++; $display("FAIL rand_gap: %0d bad gaps, required 0", gap_errs()); end
      rd(A_CNT, q);
      checks++; if (q !== exp_count) begin failures++; $display("FAIL rand_count: got %h required %h", q, exp_count); end
      rd(A_RX, q);
      checks++; if (q !== model_rx(msb)) begin failures++; $display("FAIL rand_rx: got %h required %h", q, model_rx(msb)); end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] q;
    int w1, w2, w3, e3;
    wr(A_CTRL, 32'h0);
    clear_mon();
    exp_msb = 1'b0;
    exp_words.push_back(32'h11111111);
    exp_words.push_back(32'h22222222);
    exp_words.push_back(32'h33333333);
    bus(1'b1, A_TX, 32'h11111111, q, w1);
    bus(1'b1, A_TX, 32'h22222222, q, w2);
    bus(1'b1, A_TX, 32'h33333333, q, w3);
    e3 = edge_q.size();
    checks++; if (w1 > 2) begin failures++; $display("FAIL b2b_ack1: waited %0d required <=2", w1); end
    checks++; if (w2 > 2) begin failures++; $display("FAIL b2b_ack2: waited %0d required <=2", w2); end
    checks++; if (w3 < 64*CLK_DIV-4 || w3 > 64*CLK_DIV) begin failures++; $display("FAIL b2b_ack3_stall: waited %0d required about %0d", w3, 64*CLK_DIV); end
    checks++; if (e3 != 32) begin failures++; $display("FAIL b2b_ack3_edges: %0d edges at ack, required 32", e3); end
    wait_idle();
    exp_count += 96;
    checks++; if (edge_q.size() != 96) begin failures++; $display("FAIL b2b_edges: got %0d required 96", edge_q.size()); end
    checks++; if (gap_errs() != 0) begin failures++; $display("FAIL b2b_gap: %0d bad gaps, required 0", gap_errs()); end
    checks++; if (seq_errs() != 0) begin failures++; $display("FAIL b2b_seq: %0d bad bits, required 0", seq_errs()); end
    rd(A_CNT, q);
    checks++; if (q !== exp_count) begin failures++; $display("FAIL b2b_count: got %h required %h", q, exp_count); end
  endtask

  task automatic test_chain_readback();
    logic [31:0] q, w;
    wr(A_CTRL, 32'h0);
    clear_mon();
    wr(A_TX, 32'hA5A51234);
    wr(A_TX, 32'h0);
    wait_idle();
    exp_count += 64;
    rd(A_RX, q);
    checks++; if (q !== 32'hA5A51234) begin failures++; $display("FAIL chain_lsb_rx: got %h required a5a51234", q); end
    w = $urandom;
    wr(A_CTRL, 32'h2);
    clear_mon();
    wr(A_TX, w);
    wr(A_TX, 32'h0);
    wait_idle();
    exp_count += 64;
    rd(A_RX, q);
    checks++; if (q !== w) begin failures++; $display("FAIL chain_msb_rx: got %h required %h", q, w); end
    rd(A_CNT, q);
    checks++; if (q !== exp_count) begin failures++; $display("FAIL chain_count: got %h required %h", q, exp_count); end
  endtask

  task automatic test_msb_irq();
    logic [31:0] q;
    wr(A_STATUS, 32'h4);
    wr(A_CTRL, 32'h6);
    repeat (2) @(posedge clk);
    #1;
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL irq_pre: got %b required 0", irq); end
    clear_mon();
    exp_msb = 1'b1;
    exp_words.push_back(32'h80000000);
    wr(A_TX, 32'h80000000);
    wait_edges(16);
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL irq_midword: got %b required 0", irq); end
    wait_idle();
    repeat (2) @(posedge clk);
    #1;
    exp_count += 32;
    checks++; if (irq !== 1'b1) begin failures++; $display("FAIL irq_done: got %b required 1", irq); end
    checks++; if (head_q.size() == 0 || head_q[0] !== 1'b1) begin failures++; $display("FAIL msb_first_bit: required first head bit 1"); end
    checks++; if (seq_errs() != 0) begin failures++; $display("FAIL msb_seq: %0d bad bits, required 0", seq_errs()); end
    exp_rx = model_rx(1'b1);
    rd(A_RX, q);
    checks++; if (q !== exp_rx) begin failures++; $display("FAIL msb_rx: got %h required %h", q, exp_rx); end
    wr(A_STATUS, 32'h4);
    repeat (2) @(posedge clk);
    #1;
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL irq_w1c: got %b required 0", irq); end
    rd(A_STATUS, q);
    checks++; if (q !== 32'h0) begin failures++; $display("FAIL status_w1c: got %h required 0", q); end
  endtask

  task automatic test_abort();
    logic [31:0] q, w1, w2;
    int n, e;
    wr(A_CTRL, 32'h0);
    clear_mon();
    w1 = $urandom;
    w2 = $urandom;
    wr(A_TX, w1);
    wr(A_TX, w2);
    wait_edges(10);
    wr(A_CTRL, 32'h1);
    checks++; if (pclk !== 1'b0) begin failures++; $display("FAIL abort_prog_clk: got %b required 0", pclk); end
    checks++; if (head !== 1'b0) begin failures++; $display("FAIL abort_head: got %b required 0", head); end
    n = edge_q.size();
    e = 0;
    for (int i = 0; i < n && i < 32; i++) if (head_q[i] != w1[i]) e++;
    checks++; if (n < 10 || e != 0) begin failures++; $display("FAIL abort_partial: %0d edges %0d bad bits, required >=10 and 0", n, e); end
    rd(A_STATUS, q);
    checks++; if (q !== 32'h0) begin failures++; $display("FAIL abort_status: got %h required 0", q); end
    exp_count = '0;
    rd(A_CNT, q);
    checks++; if (q !== exp_count) begin failures++; $display("FAIL abort_count: got %h required 0", q); end
    rd(A_RX, q);
    checks++; if (q !== exp_rx) begin failures++; $display("FAIL abort_rx: got %h required %h", q, exp_rx); end
    repeat (300) @(posedge clk);
    #1;
    checks++; if (edge_q.size() != n) begin failures++; $display("FAIL abort_no_edges: got %0d required %0d", edge_q.size(), n); end
    checks++; if (preset !== 1'b1) begin failures++; $display("FAIL abort_prog_reset: got %b required 1", preset); end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_random_words();
    test_back_to_back();
    test_chain_readback();
    test_msb_irq();
    test_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
